// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared types, defaults and priority helper for the button front end
package lab_pkg;

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} db_state_t;

  localparam int DB_TICKS_DEF = 16;
  localparam int N_BTN_MAX    = 32;

  // Highest set bit wins; callers zero-extend narrower button vectors.
  function automatic logic [N_BTN_MAX-1:0] onehot_msb(input logic [N_BTN_MAX-1:0] v);
    logic [N_BTN_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < N_BTN_MAX; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - N-bit two-flop synchroniser with synchronous reset
module btn_sync #(
  parameter int N = 4
) (
  input  logic         clk_pi,
  input  logic         rst_pi,
  input  logic [N-1:0] d_pi,
  output logic [N-1:0] q_po
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_pi;
      r_sync <= r_meta;
    end
  end

  assign q_po = r_sync;

endmodule

// File: rtl/btn_op_debouncer.sv
// rtl/btn_op_debouncer.sv - debounces push-buttons and latches the accepted press as a one-hot opcode
module btn_op_debouncer
  import lab_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int DB_TICKS = DB_TICKS_DEF,
  parameter int CNT_W    = 5
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic             clk_en_pi,
  input  logic [N_BTN-1:0] btn_pi,
  output logic [N_BTN-1:0] op_po,
  output logic             op_valid_po,
  output logic [N_BTN-1:0] press_pulse_po,
  output logic             busy_po
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

  logic [N_BTN-1:0]     w_s;
  logic [N_BTN-1:0]     w_s_oh;
  logic [N_BTN_MAX-1:0] w_oh_ext;
  logic                 w_unused_hi;

  db_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N_BTN-1:0] r_cand, w_cand_nxt;
  logic             w_accept;
  logic [N_BTN-1:0] r_op;
  logic             r_valid;
  logic [N_BTN-1:0] r_pulse;

  btn_sync #(.N(N_BTN)) u_sync (
    .clk_pi (clk_pi),
    .rst_pi (rst_pi),
    .d_pi   (btn_pi),
    .q_po   (w_s)
  );

  assign w_oh_ext    = onehot_msb(N_BTN_MAX'(w_s));
  assign w_s_oh      = w_oh_ext[N_BTN-1:0];
  assign w_unused_hi = ^w_oh_ext;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_s != '0) begin
          w_cand_nxt  = w_s_oh;
          w_cnt_nxt   = '0;
          w_state_nxt = DB_PRESS;
        end
      end
      DB_PRESS: begin
        // A changed candidate beats a coincident tick; IDLE re-picks it.
        if (w_s_oh != r_cand) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (clk_en_pi) begin
          if (r_cnt == CNT_LAST) begin
            w_accept    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      HELD: begin
        if (w_s == '0) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DB_REL;
        end
      end
      DB_REL: begin
        if (w_s != '0) begin
          w_cnt_nxt   = '0;
          w_state_nxt = HELD;
        end else if (clk_en_pi) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
      r_pulse <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_pulse <= w_accept ? r_cand : '0;
      if (w_accept) begin
        r_op    <= r_cand;
        r_valid <= 1'b1;
      end
    end
  end

  assign op_po          = r_op;
  assign op_valid_po    = r_valid;
  assign press_pulse_po = r_pulse;
  assign busy_po        = (r_state != IDLE);

endmodule

// File: tb/tb_btn_op_debouncer.sv
// tb/tb_btn_op_debouncer.sv - directed vector bench for btn_op_debouncer
module tb_btn_op_debouncer;

  logic       clk_pi = 1'b0;
  logic       rst_pi = 1'b1;
  logic       clk_en_pi = 1'b0;
  logic [3:0] btn_pi = 4'b0000;
  logic [3:0] op_po;
  logic       op_valid_po;
  logic [3:0] press_pulse_po;
  logic       busy_po;

  btn_op_debouncer #(.N_BTN(4), .DB_TICKS(4), .CNT_W(3)) dut (
    .clk_pi         (clk_pi),
    .rst_pi         (rst_pi),
    .clk_en_pi      (clk_en_pi),
    .btn_pi         (btn_pi),
    .op_po          (op_po),
    .op_valid_po    (op_valid_po),
    .press_pulse_po (press_pulse_po),
    .busy_po        (busy_po)
  );

  always #5 clk_pi = ~clk_pi;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] exp_pulse;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[6];

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc;
  int         pulse_cnt;
  int         pulse_cyc;
  logic [3:0] pulse_val;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock; tick after every 4th edge, pulses recorded with the edge index.
  task automatic step();
    @(posedge clk_pi);
    #1;
    cyc++;
    clk_en_pi = (cyc % 4 == 0);
    if (press_pulse_po != 4'b0000) begin
      pulse_cnt++;
      pulse_val = press_pulse_po;
      pulse_cyc = cyc;
    end
  endtask

  task automatic start_scn(input logic [3:0] b);
    rst_pi    = 1'b1;
    btn_pi    = 4'b0000;
    clk_en_pi = 1'b0;
    repeat (3) begin
      @(posedge clk_pi);
      #1;
    end
    rst_pi    = 1'b0;
    cyc       = 0;
    pulse_cnt = 0;
    pulse_cyc = -1;
    pulse_val = 4'b0000;
    btn_pi    = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0010, 4'b0010, 17};
    vecs[1] = '{4'b0101, 4'b0100, 17};
    vecs[2] = '{4'b1111, 4'b1000, 17};
    vecs[3] = '{4'b0001, 4'b0001, 17};
    vecs[4] = '{4'b0110, 4'b0100, 17};
    vecs[5] = '{4'b1000, 4'b1000, 17};

    // Reset with all buttons pressed
    rst_pi = 1'b1;
    btn_pi = 4'b1111;
    repeat (3) begin
      @(posedge clk_pi);
      #1;
    end
    check("reset_op", op_po, 4'b0000);
    check("reset_valid", op_valid_po, 0);
    check("reset_pulse", press_pulse_po, 4'b0000);
    check("reset_busy", busy_po, 0);

    // Clean presses, release, opcode held
    for (int i = 0; i < 6; i++) begin
      start_scn(vecs[i].btn);
      repeat (40) step();
      check($sformatf("v%0d_pulse_cnt", i), pulse_cnt, 1);
      check($sformatf("v%0d_pulse_val", i), pulse_val, vecs[i].exp_pulse);
      check($sformatf("v%0d_pulse_cyc", i), pulse_cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d_op", i), op_po, vecs[i].exp_pulse);
      check($sformatf("v%0d_valid", i), op_valid_po, 1);
      check($sformatf("v%0d_busy_held", i), busy_po, 1);
      btn_pi = 4'b0000;
      repeat (30) step();
      check($sformatf("v%0d_busy_rel", i), busy_po, 0);
      check($sformatf("v%0d_op_rel", i), op_po, vecs[i].exp_pulse);
      check($sformatf("v%0d_pulse_cnt_rel", i), pulse_cnt, 1);
    end

    // Bounce 0010/0000 every 3 clocks for 30 clocks, then stable
    start_scn(4'b0010);
    repeat (60) begin
      step();
      if (cyc < 30) btn_pi = ((cyc / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
      else          btn_pi = 4'b0010;
      if (cyc == 30) check("bounce_no_early_pulse", pulse_cnt, 0);
    end
    check("bounce_pulse_cnt", pulse_cnt, 1);
    check("bounce_pulse_cyc", pulse_cyc, 49);
    check("bounce_op", op_po, 4'b0010);

    // Hold then add a higher button, release, re-press same button
    start_scn(4'b0001);
    repeat (25) step();
    check("add_first_pulse", pulse_cnt, 1);
    check("add_first_op", op_po, 4'b0001);
    pulse_cnt = 0;
    btn_pi = 4'b1001;
    repeat (20) step();
    check("add_no_pulse", pulse_cnt, 0);
    check("add_op_kept", op_po, 4'b0001);
    check("add_busy", busy_po, 1);
    btn_pi = 4'b0000;
    repeat (30) step();
    check("add_rel_busy", busy_po, 0);
    pulse_cnt = 0;
    btn_pi = 4'b0001;
    repeat (30) step();
    check("repress_pulse_cnt", pulse_cnt, 1);
    check("repress_pulse_val", pulse_val, 4'b0001);
    check("repress_op", op_po, 4'b0001);

    // Reset after two ticks of debounce
    start_scn(4'b0010);
    repeat (10) step();
    check("mid_busy_before", busy_po, 1);
    rst_pi = 1'b1;
    btn_pi = 4'b0000;
    repeat (2) step();
    rst_pi = 1'b0;
    check("mid_busy_after", busy_po, 0);
    check("mid_op", op_po, 4'b0000);
    check("mid_valid", op_valid_po, 0);
    repeat (30) step();
    check("mid_no_pulse", pulse_cnt, 0);
    check("mid_valid_late", op_valid_po, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
